// File: rtl/note_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : note_sequencer_if
// Brief    : Control, song-ROM and tone-generator signals of note_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface note_sequencer_if #(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6,
    parameter int IDX_W  = 5
);
    logic                      play;
    logic                      reset_play;
    logic [1:0]                song;
    logic                      beat;
    logic [IDX_W+1:0]          rom_addr;
    logic [NOTE_W+DUR_W-1:0]   rom_data;
    logic [NOTE_W-1:0]         note;
    logic                      note_valid;
    logic                      new_note;
    logic                      song_done;

    // Sequencer side.
    modport master (
        input  play, reset_play, song, beat, rom_data,
        output rom_addr, note, note_valid, new_note, song_done
    );

    // Controller / ROM / tone-generator side.
    modport slave (
        output play, reset_play, song, beat, rom_data,
        input  rom_addr, note, note_valid, new_note, song_done
    );
endinterface
`default_nettype wire

// File: rtl/note_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : note_sequencer
// Brief    : Steps through a song's {note, duration} table and drives the tone
//            generator, holding each note for its duration in beats.
// Revision : 1.0 - initial release
// ============================================================================
module note_sequencer #(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6,
    parameter int IDX_W  = 5
) (
    input wire               clk,
    input wire               reset,
    note_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LATCH = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [IDX_W-1:0] c_last_idx = '1;
    localparam logic [DUR_W-1:0] c_one_beat = DUR_W'(1);

    state_t              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [1:0]          r_song;
    logic [DUR_W-1:0]    r_cnt;
    logic [NOTE_W-1:0]   r_note;
    logic                r_note_valid;
    logic                r_new_note;
    logic                r_song_done;

    logic [NOTE_W-1:0]   w_rom_note;
    logic [DUR_W-1:0]    w_rom_dur;
    logic                w_count_beat;

    assign w_rom_note   = bus.rom_data[NOTE_W+DUR_W-1:DUR_W];
    assign w_rom_dur    = bus.rom_data[DUR_W-1:0];
    assign w_count_beat = bus.play && bus.beat;

    assign bus.rom_addr   = {r_song, r_idx};
    assign bus.note       = r_note;
    assign bus.note_valid = r_note_valid;
    assign bus.new_note   = r_new_note;
    assign bus.song_done  = r_song_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_song       <= '0;
            r_cnt        <= '0;
            r_note       <= '0;
            r_note_valid <= 1'b0;
            r_new_note   <= 1'b0;
            r_song_done  <= 1'b0;
        end else if (bus.reset_play) begin
            // song_q is kept; a new song is only picked up on the next IDLE exit.
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_note_valid <= 1'b0;
            r_new_note   <= 1'b0;
            r_song_done  <= 1'b0;
        end else begin
            r_new_note <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.play) begin
                        r_song  <= bus.song;
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_LATCH;
                end
                ST_LATCH: begin
                    if (w_rom_dur == '0) begin
                        r_state      <= ST_DONE;
                        r_song_done  <= 1'b1;
                        r_note_valid <= 1'b0;
                    end else begin
                        r_note       <= w_rom_note;
                        r_cnt        <= w_rom_dur;
                        r_new_note   <= 1'b1;
                        r_note_valid <= (w_rom_note != '0) && bus.play;
                        r_state      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    r_note_valid <= (r_note != '0) && bus.play;
                    // Beats during pause are dropped, not queued.
                    if (w_count_beat) begin
                        if (r_cnt != c_one_beat) begin
                            r_cnt <= r_cnt - c_one_beat;
                        end else begin
                            r_note_valid <= 1'b0;
                            if (r_idx == c_last_idx) begin
                                r_state     <= ST_DONE;
                                r_song_done <= 1'b1;
                            end else begin
                                r_idx   <= r_idx + 1'b1;
                                r_state <= ST_FETCH;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    r_song_done  <= 1'b1;
                    r_note_valid <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_note_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_sequencer
// Brief    : Directed self-checking bench for note_sequencer with a song-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_note_sequencer;

    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;
    localparam int IDX_W  = 5;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   nn_count = 0;

    logic [11:0] mem [0:3][0:31];

    always #5 clk = ~clk;

    note_sequencer_if #(.NOTE_W(NOTE_W), .DUR_W(DUR_W), .IDX_W(IDX_W)) bus ();

    note_sequencer #(.NOTE_W(NOTE_W), .DUR_W(DUR_W), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous song ROM
    always @(posedge clk)
        bus.rom_data <= mem[bus.rom_addr[6:5]][bus.rom_addr[4:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Song-level model: position in the table, beats left, cycles until the next word lands.
    logic m_valid = 1'b0;
    logic m_idle, m_done;
    int   m_wait, m_idx, m_song, m_rem, m_note;
    logic e_nv, e_nn, e_done;

    task automatic model_step();
        logic [11:0] w;
        int nt, dur;
        if (reset) begin
            m_valid = 1'b1; m_idle = 1'b1; m_done = 1'b0; m_wait = 0;
            m_idx = 0; m_song = 0; m_rem = 0; m_note = 0;
            e_nv = 1'b0; e_nn = 1'b0; e_done = 1'b0;
        end else if (bus.reset_play) begin
            m_idle = 1'b1; m_done = 1'b0; m_wait = 0; m_idx = 0;
            e_nv = 1'b0; e_nn = 1'b0; e_done = 1'b0;
        end else begin
            e_nn = 1'b0;
            if (m_done) begin
                e_nv = 1'b0;
            end else if (m_idle) begin
                if (bus.play) begin
                    m_idle = 1'b0;
                    m_song = int'(bus.song);
                    m_wait = 2;
                end
            end else if (m_wait == 2) begin
                m_wait = 1;
            end else if (m_wait == 1) begin
                m_wait = 0;
                w   = mem[m_song][m_idx];
                nt  = int'(w[11:6]);
                dur = int'(w[5:0]);
                if (dur == 0) begin
                    m_done = 1'b1; e_done = 1'b1; e_nv = 1'b0;
                end else begin
                    m_note = nt; m_rem = dur; e_nn = 1'b1;
                    e_nv = (nt != 0) && bus.play;
                end
            end else begin
                e_nv = (m_note != 0) && bus.play;
                if (bus.play && bus.beat) begin
                    m_rem--;
                    if (m_rem == 0) begin
                        e_nv = 1'b0;
                        if (m_idx == 31) begin
                            m_done = 1'b1; e_done = 1'b1;
                        end else begin
                            m_idx++;
                            m_wait = 2;
                        end
                    end
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            if (bus.new_note === 1'b1) nn_count++;
            chk("cyc_note_valid", 32'(bus.note_valid), 32'(e_nv));
            chk("cyc_new_note",   32'(bus.new_note),   32'(e_nn));
            chk("cyc_song_done",  32'(bus.song_done),  32'(e_done));
            chk("cyc_note",       32'(bus.note),       32'(m_note));
            chk("cyc_rom_addr",   32'(bus.rom_addr),   32'(m_song * 32 + m_idx));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_beat();
        bus.beat = 1'b1;
        step();
        bus.beat = 1'b0;
    endtask

    function automatic logic [11:0] word(input int nt, input int dur);
        return 12'(nt * 64 + dur);
    endfunction

    initial begin
        for (int s = 0; s < 4; s++)
            for (int i = 0; i < 32; i++)
                mem[s][i] = 12'h000;
        for (int i = 0; i < 32; i++) mem[0][i] = word(i + 1, 1);
        mem[1][0] = word(5, 2);  mem[1][1] = word(7, 1);
        mem[2][0] = word(9, 4);  mem[2][1] = word(3, 1);
        mem[3][0] = word(0, 3);  mem[3][1] = word(11, 1);

        bus.play = 1'b0; bus.reset_play = 1'b0; bus.song = 2'd0; bus.beat = 1'b0;
        step(); step();
        chk("rst_note_valid", 32'(bus.note_valid), 32'd0);
        chk("rst_song_done",  32'(bus.song_done),  32'd0);
        chk("rst_rom_addr",   32'(bus.rom_addr),   32'h00);
        chk("rst_note",       32'(bus.note),       32'd0);

        // Song 1: {5,2},{7,1},{0,0}
        reset = 1'b0; bus.song = 2'd1; bus.play = 1'b1; nn_count = 0;
        step();
        chk("s1_addr0", 32'(bus.rom_addr), 32'h20);
        step();
        chk("s1_latch_nv", 32'(bus.note_valid), 32'd0);
        step();
        chk("s1_note5", 32'(bus.note), 32'd5);
        chk("s1_nn5",   32'(bus.new_note), 32'd1);
        step();
        chk("s1_nn_low", 32'(bus.new_note), 32'd0);
        do_beat();
        chk("s1_still0", 32'(bus.rom_addr), 32'h20);
        do_beat();
        chk("s1_addr1", 32'(bus.rom_addr), 32'h21);
        step(); step();
        chk("s1_note7", 32'(bus.note), 32'd7);
        do_beat();
        step(); step();
        chk("s1_done", 32'(bus.song_done), 32'd1);
        chk("s1_nn_count", 32'(nn_count), 32'd2);

        // Song change in DONE ignored; reset_play restarts; latency from play
        bus.song = 2'd2;
        step();
        chk("done_sticky", 32'(bus.song_done), 32'd1);
        chk("done_addr",   32'(bus.rom_addr),  32'h22);
        bus.reset_play = 1'b1; bus.play = 1'b0;
        step();
        chk("rp_done_sd",   32'(bus.song_done), 32'd0);
        chk("rp_done_addr", 32'(bus.rom_addr),  32'h20);
        bus.reset_play = 1'b0; bus.play = 1'b1;
        step();
        chk("s2_addr0", 32'(bus.rom_addr), 32'h40);
        step();
        chk("lat_n1_nv", 32'(bus.note_valid), 32'd0);
        step();
        chk("lat_n2_nv", 32'(bus.note_valid), 32'd1);
        chk("lat_n2_nn", 32'(bus.new_note),   32'd1);
        chk("s2_note9",  32'(bus.note),       32'd9);
        step();
        chk("lat_n3_nn", 32'(bus.new_note), 32'd0);

        // Pause after one beat of a 4-beat note; paused beats are dropped
        do_beat();
        bus.play = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            do_beat();
            chk("pause_nv",   32'(bus.note_valid), 32'd0);
            chk("pause_note", 32'(bus.note),       32'd9);
        end
        bus.play = 1'b1;
        step();
        chk("resume_nv", 32'(bus.note_valid), 32'd1);
        do_beat(); do_beat();
        chk("resume_hold", 32'(bus.rom_addr), 32'h40);
        do_beat();
        chk("resume_fetch", 32'(bus.rom_addr), 32'h41);
        step(); step();
        chk("s2_note3", 32'(bus.note), 32'd3);

        // reset_play in HOLD
        bus.reset_play = 1'b1; bus.play = 1'b0;
        step();
        chk("rp_hold_nv",   32'(bus.note_valid), 32'd0);
        chk("rp_hold_addr", 32'(bus.rom_addr),   32'h40);
        bus.reset_play = 1'b0;

        // Rest word {0,3}
        bus.song = 2'd3; bus.play = 1'b1;
        step(); step(); step();
        chk("rest_nn", 32'(bus.new_note),   32'd1);
        chk("rest_nv", 32'(bus.note_valid), 32'd0);
        do_beat(); do_beat();
        chk("rest_hold", 32'(bus.rom_addr), 32'h60);
        do_beat();
        chk("rest_next", 32'(bus.rom_addr), 32'h61);
        step(); step();
        chk("rest_note11", 32'(bus.note), 32'd11);

        // Full 32-entry table without an end marker
        bus.reset_play = 1'b1; bus.play = 1'b0;
        step();
        bus.reset_play = 1'b0; bus.song = 2'd0; bus.play = 1'b1;
        step();
        for (int i = 0; i < 32; i++) begin
            step(); step();
            chk("full_note", 32'(bus.note), 32'(i + 1));
            do_beat();
        end
        chk("full_done", 32'(bus.song_done), 32'd1);
        chk("full_addr", 32'(bus.rom_addr),  32'h1F);
        step(); step(); step();
        chk("full_no_wrap", 32'(bus.rom_addr), 32'h1F);

        reset = 1'b1;
        step();
        chk("final_rst_sd", 32'(bus.song_done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
